// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, constants and types for the instruction fetch unit
package inst_fetch_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam int FQ_DEPTH      = 2;
  localparam int PC_STEP       = 4;

  localparam logic [INST_BUS-1:0]      ZERO_WORD        = 32'h0000_0000;
  localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_en_e;

endpackage

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - two-entry {pc, inst} queue between fetch and decode
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int INST_W = INST_BUS,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  input  logic              clear,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic              head;
  logic              tail;
  logic              pop_ok;
  logic              push_ok;

  assign head_valid = (count != 2'd0);
  assign pop_ok     = pop & head_valid;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok    = push & ((count < 2'(DEPTH)) | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= ZERO_WORD[INST_W-1:0];
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (clear) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push_ok) begin
        pc_mem[tail]   <= push_pc;
        inst_mem[tail] <= push_inst;
        tail           <= ~tail;
      end
      if (pop_ok) begin
        head <= ~head;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head_pc   = pc_mem[head];
  assign head_inst = inst_mem[head];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC, ROM enable, redirect handling and decode handoff
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0],
  parameter int                DEPTH    = FQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i
);

  chip_en_e          ce;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic              head_valid;
  logic              pop;
  logic              push;
  logic              enabled;
  logic [1:0]        unused_redirect_lsb;

  assign enabled             = (ce == CHIP_ENABLE);
  assign unused_redirect_lsb = redirect_pc_i[1:0];

  // A redirect discards whatever decode would have taken this cycle.
  assign pop  = head_valid & id_ready_i & ~flush_i;
  assign push = enabled & ~flush_i & ~stall_i & ((count < 2'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce <= CHIP_DISABLE;
      pc <= RESET_PC;
    end else begin
      ce <= CHIP_ENABLE;
      if (enabled) begin
        if (flush_i) begin
          pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end else if (push) begin
          pc <= pc + ADDR_W'(PC_STEP);
        end
      end
    end
  end

  assign rom_ce_o   = enabled;
  assign rom_addr_o = pc;

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (pc),
    .push_inst  (rom_inst_i),
    .pop        (pop),
    .clear      (flush_i),
    .count      (count),
    .head_valid (head_valid),
    .head_pc    (id_pc_o),
    .head_inst  (id_inst_o)
  );

  assign id_valid_o = head_valid;

endmodule
